// File: rtl/coreuart_tx_pkg.sv
// Shared definitions for the CoreUART transmit path.
//   tx_state_e          : serializer FSM states
//   OVERSAMPLE_DEFAULT  : baud_tick pulses per transmitted bit
//   RD_LATENCY_DEFAULT  : clocks from the FIFO pop cycle to valid read data
package coreuart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5
  } tx_state_e;

  localparam int OVERSAMPLE_DEFAULT = 16;
  localparam int RD_LATENCY_DEFAULT = 2;

endpackage

// File: rtl/coreuart_tx_bit_timer.sv
// Bit-period timer for the UART transmitter.
// Counts baud_tick pulses and flags the last tick of each bit.
// Ports:
//   clock     : system clock
//   reset_n   : synchronous active-low reset
//   clear     : holds the counter at zero (used while no bit is on the line)
//   baud_tick : one-cycle enable at OVERSAMPLE x baud
//   bit_done  : high on the baud_tick that completes the current bit
module coreuart_tx_bit_timer
  import coreuart_tx_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic baud_tick,
  output logic bit_done
);

  localparam int CNT_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(OVERSAMPLE - 1);

  logic [CNT_W-1:0] tick_cnt;

  // Tick counter: wraps after the last tick of a bit so consecutive bits
  // line up without the FSM having to touch it.
  always_ff @(posedge clock) begin
    if (!reset_n || clear) begin
      tick_cnt <= '0;
    end else if (baud_tick) begin
      tick_cnt <= (tick_cnt == LAST_TICK) ? '0 : tick_cnt + CNT_W'(1);
    end
  end

  assign bit_done = baud_tick && !clear && (tick_cnt == LAST_TICK);

endmodule

// File: rtl/coreuart_tx_fifo_serializer.sv
// CoreUART transmit serializer on the read side of the TX byte FIFO.
// Pops one byte at a time and sends start / 7 or 8 data bits LSB first /
// optional parity / one stop bit. Line format is frozen for each frame at
// the moment the popped byte is loaded.
// Ports:
//   clock       : system clock, all state on rising edge
//   reset_n     : synchronous active-low reset
//   baud_tick   : one-cycle enable at OVERSAMPLE x baud
//   bit8        : 1 = 8 data bits, 0 = 7 data bits
//   parity_en   : 1 = append parity bit
//   odd_n_even  : 1 = odd parity, 0 = even parity
//   fifo_empty  : TX FIFO empty flag
//   fifo_data   : TX FIFO registered read data
//   fifo_read_n : FIFO pop strobe, active low, one cycle per byte
//   tx          : serial line, idle high
//   tx_busy     : high from pop until the end of the stop bit
module coreuart_tx_fifo_serializer
  import coreuart_tx_pkg::*;
#(
  parameter int RD_LATENCY = RD_LATENCY_DEFAULT,
  parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       baud_tick,
  input  logic       bit8,
  input  logic       parity_en,
  input  logic       odd_n_even,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_read_n,
  output logic       tx,
  output logic       tx_busy
);

  localparam int FETCH_W = (RD_LATENCY > 0) ? $clog2(RD_LATENCY + 1) : 1;
  localparam logic [FETCH_W-1:0] FETCH_LAST = FETCH_W'(RD_LATENCY);

  tx_state_e          state_q, state_d;
  logic [FETCH_W-1:0] fetch_cnt;
  logic [7:0]         shift_q;
  logic [2:0]         bit_cnt;
  logic [2:0]         last_bit;
  logic               parity_acc;
  logic               bit8_q, parity_en_q, odd_q;
  logic               tx_d, read_n_d, busy_d;
  logic               load_frame, send_bit;
  logic               timer_clear, bit_done;

  // The bit timer only runs while a bit is on the line; holding it clear in
  // IDLE/FETCH makes every frame start with a fresh full-length start bit.
  assign timer_clear = (state_q == IDLE) || (state_q == FETCH);
  assign last_bit    = bit8_q ? 3'd7 : 3'd6;

  coreuart_tx_bit_timer #(
    .OVERSAMPLE (OVERSAMPLE)
  ) u_bit_timer (
    .clock     (clock),
    .reset_n   (reset_n),
    .clear     (timer_clear),
    .baud_tick (baud_tick),
    .bit_done  (bit_done)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and next-output decode. tx is registered, so the value chosen
  // here is the level for the bit that starts on the coming edge.
  always_comb begin
    state_d    = state_q;
    tx_d       = tx;
    read_n_d   = 1'b1;
    busy_d     = tx_busy;
    load_frame = 1'b0;
    send_bit   = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          state_d  = FETCH;
          read_n_d = 1'b0;
          busy_d   = 1'b1;
        end
      end
      FETCH: begin
        if (fetch_cnt == FETCH_LAST) begin
          load_frame = 1'b1;
          state_d    = START;
          tx_d       = 1'b0;
        end
      end
      START: begin
        if (bit_done) begin
          state_d  = DATA;
          tx_d     = shift_q[0];
          send_bit = 1'b1;
        end
      end
      DATA: begin
        if (bit_done) begin
          if (bit_cnt == last_bit) begin
            if (parity_en_q) begin
              state_d = PARITY;
              tx_d    = parity_acc ^ odd_q;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            tx_d     = shift_q[0];
            send_bit = 1'b1;
          end
        end
      end
      PARITY: begin
        if (bit_done) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
      STOP: begin
        if (bit_done) begin
          state_d = IDLE;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Datapath and output registers. The parity accumulator folds in each data
  // bit as it is put on the line, so it is complete when the last data bit ends.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      fifo_read_n <= 1'b1;
      tx          <= 1'b1;
      tx_busy     <= 1'b0;
      fetch_cnt   <= '0;
      shift_q     <= '0;
      bit_cnt     <= '0;
      parity_acc  <= 1'b0;
      bit8_q      <= 1'b0;
      parity_en_q <= 1'b0;
      odd_q       <= 1'b0;
    end else begin
      fifo_read_n <= read_n_d;
      tx          <= tx_d;
      tx_busy     <= busy_d;

      if ((state_q == FETCH) && !load_frame) begin
        fetch_cnt <= fetch_cnt + FETCH_W'(1);
      end else begin
        fetch_cnt <= '0;
      end

      if (load_frame) begin
        shift_q     <= fifo_data;
        bit8_q      <= bit8;
        parity_en_q <= parity_en;
        odd_q       <= odd_n_even;
        parity_acc  <= 1'b0;
        bit_cnt     <= '0;
      end else if (send_bit) begin
        shift_q    <= {1'b0, shift_q[7:1]};
        parity_acc <= parity_acc ^ shift_q[0];
        if (state_q == DATA) begin
          bit_cnt <= bit_cnt + 3'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_coreuart_tx_fifo_serializer.sv
// Self-checking bench for coreuart_tx_fifo_serializer.
// A queue-based FIFO model with two-cycle read latency feeds the DUT; each
// frame is checked bit by bit at mid-bit against a frame built from the byte
// and line format, and the frame length is checked through tx_busy.
module tb_coreuart_tx_fifo_serializer;

  localparam int OVS    = 16;
  localparam int RD_LAT = 2;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       baud_tick;
  logic       bit8, parity_en, odd_n_even;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       fifo_read_n;
  logic       tx;
  logic       tx_busy;

  int         checks = 0;
  int         passes = 0;
  int         baud_div = 4;
  int         pops = 0;
  int         exp_pops = 0;
  bit         underflow = 0;
  logic [7:0] fifo_q[$];
  logic [7:0] stage1;
  bit         pop_seen;

  coreuart_tx_fifo_serializer dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .baud_tick   (baud_tick),
    .bit8        (bit8),
    .parity_en   (parity_en),
    .odd_n_even  (odd_n_even),
    .fifo_empty  (fifo_empty),
    .fifo_data   (fifo_data),
    .fifo_read_n (fifo_read_n),
    .tx          (tx),
    .tx_busy     (tx_busy)
  );

  // Clock generation.
  initial forever #5 clock = ~clock;

  // Baud tick: one pulse every baud_div clocks.
  initial begin
    int div_cnt;
    div_cnt   = 0;
    baud_tick = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      div_cnt++;
      if (div_cnt >= baud_div) begin
        div_cnt   = 0;
        baud_tick = 1'b1;
      end else begin
        baud_tick = 1'b0;
      end
    end
  end

  // FIFO model: a pop seen in cycle F0 reaches fifo_data in cycle F0+2.
  initial begin
    fifo_empty = 1'b1;
    fifo_data  = 8'h00;
    stage1     = 8'h00;
    forever begin
      @(negedge clock);
      pop_seen = (fifo_read_n === 1'b0);
      @(posedge clock);
      #1;
      fifo_data = stage1;
      if (pop_seen) begin
        pops++;
        if (fifo_q.size() == 0) underflow = 1'b1;
        else stage1 = fifo_q.pop_front();
      end
      fifo_empty = (fifo_q.size() == 0);
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) passes++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
  endtask

  // Set the line format and queue one byte into the FIFO model.
  task automatic applyStimulus(input logic [7:0] data, input bit b8, input bit pe, input bit odd);
    @(posedge clock);
    #1;
    bit8       = b8;
    parity_en  = pe;
    odd_n_even = odd;
    fifo_q.push_back(data);
  endtask

  // Wait for the falling edge of a start bit; gap counts idle-high cycles seen.
  task automatic waitStart(output int gap, output bit ok);
    gap = 0;
    ok  = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clock);
      if (tx === 1'b0) begin
        ok = 1'b1;
        return;
      end
      gap++;
    end
  endtask

  // Expect one complete frame for the given byte and line format.
  task automatic expectFrame(input logic [7:0] data, input bit b8, input bit pe, input bit odd,
                             input bit scramble, output int gap);
    bit exp_bits[$];
    int ones, nb, tcount, total, limit, idx;
    bit ok, done;
    ones = 0;
    nb   = b8 ? 8 : 7;
    exp_bits.push_back(1'b0);
    for (int i = 0; i < nb; i++) begin
      exp_bits.push_back(data[i]);
      ones += int'(data[i]);
    end
    if (pe) exp_bits.push_back(((ones % 2) == 1) ^ odd);
    exp_bits.push_back(1'b1);
    total = exp_bits.size() * OVS;

    waitStart(gap, ok);
    checkOutput("start_seen", 32'(ok), 32'd1);
    if (!ok) return;
    checkOutput("busy_in_start", 32'(tx_busy), 32'd1);
    if (scramble) begin
      bit8       = 1'($urandom_range(0, 1));
      parity_en  = 1'($urandom_range(0, 1));
      odd_n_even = 1'($urandom_range(0, 1));
    end

    tcount = 0;
    done   = 1'b0;
    limit  = total * (baud_div + 1) + 100;
    for (int cyc = 0; cyc < limit && !done; cyc++) begin
      if (cyc > 0) @(negedge clock);
      if (baud_tick === 1'b1) begin
        tcount++;
        if ((tcount % OVS) == (OVS / 2)) begin
          idx = tcount / OVS;
          checkOutput($sformatf("bit%0d_of_%02h", idx, data), 32'(tx), 32'(exp_bits[idx]));
        end
        if (tcount == total) done = 1'b1;
      end
    end
    checkOutput("frame_ticks", 32'(done), 32'd1);
    if (!done) return;
    checkOutput("busy_last_tick", 32'(tx_busy), 32'd1);
    @(negedge clock);
    checkOutput("busy_after_stop", 32'(tx_busy), 32'd0);
    checkOutput("tx_after_stop", 32'(tx), 32'd1);
  endtask

  initial begin
    int  gap, tcount;
    bit  ok, reached, bad_rd, bad_tx, bad_busy;
    logic [7:0] rbyte;
    bit  rb8, rpe, rodd;

    reset_n    = 1'b0;
    bit8       = 1'b1;
    parity_en  = 1'b0;
    odd_n_even = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checkOutput("reset_tx", 32'(tx), 32'd1);
    checkOutput("reset_busy", 32'(tx_busy), 32'd0);
    checkOutput("reset_read_n", 32'(fifo_read_n), 32'd1);
    @(posedge clock);
    #1;
    reset_n = 1'b1;

    // 0x55, 8N1.
    $display("[TB] test 1: 0x55 8N1");
    baud_div = 4;
    applyStimulus(8'h55, 1'b1, 1'b0, 1'b0);
    exp_pops++;
    expectFrame(8'h55, 1'b1, 1'b0, 1'b0, 1'b0, gap);
    checkOutput("pops_t1", 32'(pops), 32'(exp_pops));

    // 0xA3 with even then odd parity.
    $display("[TB] test 2: 0xA3 8E1 / 8O1");
    applyStimulus(8'hA3, 1'b1, 1'b1, 1'b0);
    exp_pops++;
    expectFrame(8'hA3, 1'b1, 1'b1, 1'b0, 1'b0, gap);
    applyStimulus(8'hA3, 1'b1, 1'b1, 1'b1);
    exp_pops++;
    expectFrame(8'hA3, 1'b1, 1'b1, 1'b1, 1'b0, gap);
    checkOutput("pops_t2", 32'(pops), 32'(exp_pops));

    // 0xFF, 7 data bits, no parity.
    $display("[TB] test 3: 0xFF 7N1");
    baud_div = 2;
    applyStimulus(8'hFF, 1'b0, 1'b0, 1'b0);
    exp_pops++;
    expectFrame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, gap);

    // Two queued bytes: no pop while busy, gap after the first frame.
    $display("[TB] test 4: back-to-back 0x12 0x34");
    baud_div = 3;
    applyStimulus(8'h12, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'h34, 1'b1, 1'b0, 1'b0);
    exp_pops++;
    expectFrame(8'h12, 1'b1, 1'b0, 1'b0, 1'b0, gap);
    checkOutput("pops_after_first", 32'(pops), 32'(exp_pops));
    exp_pops++;
    expectFrame(8'h34, 1'b1, 1'b0, 1'b0, 1'b0, gap);
    checkOutput("gap_min", 32'((gap + 1) >= (RD_LAT + 2)), 32'd1);
    checkOutput("gap_max", 32'((gap + 1) <= (RD_LAT + 2 + baud_div)), 32'd1);
    checkOutput("pops_t4", 32'(pops), 32'(exp_pops));

    // Empty FIFO for 1000 clocks.
    $display("[TB] test 5: idle with empty FIFO");
    bad_rd = 0; bad_tx = 0; bad_busy = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clock);
      if (fifo_read_n !== 1'b1) bad_rd = 1;
      if (tx !== 1'b1) bad_tx = 1;
      if (tx_busy !== 1'b0) bad_busy = 1;
    end
    checkOutput("idle_read_n", 32'(bad_rd), 32'd0);
    checkOutput("idle_tx", 32'(bad_tx), 32'd0);
    checkOutput("idle_busy", 32'(bad_busy), 32'd0);

    // Reset in the middle of data bit 3.
    $display("[TB] test 6: reset during DATA bit 3");
    baud_div = 4;
    applyStimulus(8'h5A, 1'b1, 1'b0, 1'b0);
    exp_pops++;
    waitStart(gap, ok);
    checkOutput("rst_start_seen", 32'(ok), 32'd1);
    if (ok) begin
      tcount  = 0;
      reached = 0;
      for (int cyc = 0; cyc < 2000 && !reached; cyc++) begin
        if (cyc > 0) @(negedge clock);
        if (baud_tick === 1'b1) tcount++;
        if (tcount == 4 * OVS + OVS / 2) reached = 1;
      end
      checkOutput("rst_reached_bit3", 32'(reached), 32'd1);
      checkOutput("rst_data_bit3", 32'(tx), 32'd1);
    end
    @(posedge clock);
    #1;
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    @(negedge clock);
    checkOutput("rst_mid_tx", 32'(tx), 32'd1);
    checkOutput("rst_mid_busy", 32'(tx_busy), 32'd0);
    checkOutput("rst_mid_read_n", 32'(fifo_read_n), 32'd1);
    applyStimulus(8'hC3, 1'b1, 1'b1, 1'b0);
    exp_pops++;
    expectFrame(8'hC3, 1'b1, 1'b1, 1'b0, 1'b0, gap);
    checkOutput("pops_t6", 32'(pops), 32'(exp_pops));

    // Random bytes and formats; format inputs change mid-frame.
    $display("[TB] random frames");
    for (int r = 0; r < 6; r++) begin
      rbyte    = 8'($urandom);
      rb8      = 1'($urandom_range(0, 1));
      rpe      = 1'($urandom_range(0, 1));
      rodd     = 1'($urandom_range(0, 1));
      baud_div = $urandom_range(1, 5);
      applyStimulus(rbyte, rb8, rpe, rodd);
      exp_pops++;
      expectFrame(rbyte, rb8, rpe, rodd, 1'b1, gap);
    end
    checkOutput("pops_final", 32'(pops), 32'(exp_pops));
    checkOutput("no_underflow", 32'(underflow), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
